// File: rtl/fifo_bank.sv
// Bank of NCH independent first-word-fall-through FIFOs sharing clock, reset and clear.
// Optional macro FIFO_BANK_ERR_EN adds sticky per-channel overflow/underflow flags on ERR.
module fifo_bank #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   parameter  int NCH   = 2,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLR,
   input  logic [NCH-1:0]       ENQ,
   input  logic [NCH-1:0]       DEQ,
   input  logic [NCH*WIDTH-1:0] D_IN,
   output logic [NCH-1:0]       FULL_N,
   output logic [NCH-1:0]       EMPTY_N,
   output logic [NCH*WIDTH-1:0] D_OUT,
   output logic [NCH*CW-1:0]    COUNT
`ifdef FIFO_BANK_ERR_EN
   ,
   output logic [2*NCH-1:0]     ERR
`endif
);

   localparam int AW = $clog2(DEPTH);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wr_ptr;
      logic [AW-1:0]    rd_ptr;
      logic [CW-1:0]    cnt;
      logic             full;
      logic             empty;
      logic             enq_ok;
      logic             deq_ok;

      assign full   = (cnt == CW'(DEPTH));
      assign empty  = (cnt == '0);
      assign enq_ok = ENQ[i] && !full;
      assign deq_ok = DEQ[i] && !empty;

      // Pointers wrap for free because DEPTH is a power of two.
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (enq_ok) wr_ptr <= wr_ptr + AW'(1);
            if (deq_ok) rd_ptr <= rd_ptr + AW'(1);
            if (enq_ok && !deq_ok)      cnt <= cnt + CW'(1);
            else if (deq_ok && !enq_ok) cnt <= cnt - CW'(1);
         end
      end

      // NOTE: storage has no reset; stale entries are hidden by the empty mask on D_OUT.
      always_ff @(posedge CLK) begin
         if (enq_ok && !CLR) mem[wr_ptr] <= D_IN[i*WIDTH +: WIDTH];
      end

      assign FULL_N[i]                = !full;
      assign EMPTY_N[i]               = !empty;
      assign D_OUT[i*WIDTH +: WIDTH]  = empty ? '0 : mem[rd_ptr];
      assign COUNT[i*CW +: CW]        = cnt;

`ifdef FIFO_BANK_ERR_EN
      logic [1:0] err_q;

      // Bit 0 overflow, bit 1 underflow; sticky until reset or clear.
      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            err_q <= '0;
         end else if (CLR) begin
            err_q <= '0;
         end else begin
            if (ENQ[i] && full)  err_q[0] <= 1'b1;
            if (DEQ[i] && empty) err_q[1] <= 1'b1;
         end
      end

      assign ERR[2*i +: 2] = err_q;
`endif
   end

endmodule

// File: tb/tb_fifo_bank.sv
// Self-checking bench for fifo_bank: directed scenarios plus random traffic against a queue model.
module tb_fifo_bank;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int NCH   = 2;
   localparam int CW    = 3;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b0;
   logic                 CLR = 1'b0;
   logic [NCH-1:0]       ENQ = '0;
   logic [NCH-1:0]       DEQ = '0;
   logic [NCH*WIDTH-1:0] D_IN = '0;
   logic [NCH-1:0]       FULL_N;
   logic [NCH-1:0]       EMPTY_N;
   logic [NCH*WIDTH-1:0] D_OUT;
   logic [NCH*CW-1:0]    COUNT;
`ifdef FIFO_BANK_ERR_EN
   logic [2*NCH-1:0]     ERR;
`endif

   fifo_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .CLR     (CLR),
      .ENQ     (ENQ),
      .DEQ     (DEQ),
      .D_IN    (D_IN),
      .FULL_N  (FULL_N),
      .EMPTY_N (EMPTY_N),
      .D_OUT   (D_OUT),
      .COUNT   (COUNT)
`ifdef FIFO_BANK_ERR_EN
      ,
      .ERR     (ERR)
`endif
   );

   always #5 CLK = ~CLK;

   // Reference model: one queue per channel plus sticky error bits.
   logic [WIDTH-1:0] mq [NCH][$];
   logic [2*NCH-1:0] merr = '0;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   function automatic logic [CW-1:0] cnt_of(input int ch);
      return COUNT[ch*CW +: CW];
   endfunction

   function automatic logic [WIDTH-1:0] dout_of(input int ch);
      return D_OUT[ch*WIDTH +: WIDTH];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NCH; i++) mq[i].delete();
      merr = '0;
   endtask

   task automatic model_update(input logic [NCH-1:0] e, input logic [NCH-1:0] d,
                               input logic [NCH*WIDTH-1:0] din, input logic c);
      if (c) begin
         model_clear();
         return;
      end
      for (int i = 0; i < NCH; i++) begin
         int sz;
         sz = mq[i].size();
         if (e[i] && sz == DEPTH) merr[2*i]   = 1'b1;
         if (d[i] && sz == 0)     merr[2*i+1] = 1'b1;
         if (d[i] && sz != 0)     void'(mq[i].pop_front());
         if (e[i] && sz != DEPTH) mq[i].push_back(din[i*WIDTH +: WIDTH]);
      end
   endtask

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge CLK) begin
      for (int i = 0; i < NCH; i++) begin
         int sz;
         sz = mq[i].size();
         check($sformatf("full_n[%0d]", i), 32'(FULL_N[i]), 32'(sz != DEPTH));
         check($sformatf("empty_n[%0d]", i), 32'(EMPTY_N[i]), 32'(sz != 0));
         check($sformatf("count[%0d]", i), 32'(cnt_of(i)), 32'(sz));
         check($sformatf("d_out[%0d]", i), 32'(dout_of(i)), (sz != 0) ? 32'(mq[i][0]) : 32'd0);
      end
`ifdef FIFO_BANK_ERR_EN
      check("err", 32'(ERR), 32'(merr));
`endif
   end

   // One clock: drive inputs, update the model at the edge, return just after the falling edge.
   task automatic step(input logic [NCH-1:0] e, input logic [NCH-1:0] d,
                       input logic [NCH*WIDTH-1:0] din, input logic c);
      ENQ = e; DEQ = d; D_IN = din; CLR = c;
      @(posedge CLK);
      if (RST) model_update(e, d, din, c);
      @(negedge CLK);
      #1;
   endtask

   task automatic idle();
      step('0, '0, '0, 1'b0);
   endtask

   initial begin
      // 1. Reset held for two cycles
      model_clear();
      idle();
      idle();
      check("rst_full_n", 32'(FULL_N), 32'h3);
      check("rst_empty_n", 32'(EMPTY_N), 32'h0);
      check("rst_d_out", 32'(D_OUT), 32'h0);
      check("rst_count", 32'(COUNT), 32'h0);
      RST = 1'b1;
      idle();

      // 2. Fill and drain channel 0
      step(2'b01, 2'b00, 16'h0011, 1'b0);
      step(2'b01, 2'b00, 16'h0022, 1'b0);
      step(2'b01, 2'b00, 16'h0033, 1'b0);
      step(2'b01, 2'b00, 16'h0044, 1'b0);
      check("fill_full_n0", 32'(FULL_N[0]), 32'd0);
      check("fill_count0", 32'(cnt_of(0)), 32'd4);
      step(2'b01, 2'b00, 16'h0055, 1'b0);
      check("ovf_count0", 32'(cnt_of(0)), 32'd4);
      check("ovf_head0", 32'(dout_of(0)), 32'h11);
`ifdef FIFO_BANK_ERR_EN
      check("ovf_err0", 32'(ERR[0]), 32'd1);
`endif
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain_head%0d", k), 32'(dout_of(0)), 32'h11 * (k + 1));
         step(2'b00, 2'b01, 16'h0000, 1'b0);
      end
      check("drain_empty_n0", 32'(EMPTY_N[0]), 32'd0);
      check("drain_dout0", 32'(dout_of(0)), 32'd0);

      // 3. Wrap-around at constant occupancy of 2
      step(2'b01, 2'b00, 16'h0090, 1'b0);
      step(2'b01, 2'b00, 16'h0091, 1'b0);
      for (int k = 0; k < 10; k++) begin
         logic [7:0] exp_head;
         exp_head = (k < 2) ? 8'(8'h90 + k) : 8'(8'hA0 + k - 2);
         check($sformatf("wrap_head%0d", k), 32'(dout_of(0)), 32'(exp_head));
         step(2'b01, 2'b01, 16'(8'hA0 + k), 1'b0);
         check($sformatf("wrap_count%0d", k), 32'(cnt_of(0)), 32'd2);
      end

      // 4. Full and empty boundaries on channel 1
      for (int k = 0; k < 4; k++) step(2'b10, 2'b00, 16'((8'hB0 + k) << 8), 1'b0);
      check("full1_count", 32'(cnt_of(1)), 32'd4);
      step(2'b10, 2'b10, 16'hEE00, 1'b0);
      check("full1_both_count", 32'(cnt_of(1)), 32'd3);
      check("full1_both_head", 32'(dout_of(1)), 32'hB1);
      for (int k = 0; k < 3; k++) step(2'b00, 2'b10, 16'h0000, 1'b0);
      check("empty1_count", 32'(cnt_of(1)), 32'd0);
      step(2'b10, 2'b10, 16'h7E00, 1'b0);
      check("empty1_both_count", 32'(cnt_of(1)), 32'd1);
      check("empty1_both_head", 32'(dout_of(1)), 32'h7E);
`ifdef FIFO_BANK_ERR_EN
      check("udf_err3", 32'(ERR[3]), 32'd1);
`endif

      // 5. CLR wins over ENQ/DEQ with both channels at 3 entries
      step(2'b11, 2'b00, 16'h2111, 1'b0);
      step(2'b10, 2'b00, 16'h2200, 1'b0);
      check("pre_clr_count", 32'(COUNT), 32'({3'd3, 3'd3}));
      step(2'b11, 2'b11, 16'h5566, 1'b1);
      check("clr_count", 32'(COUNT), 32'h0);
      check("clr_empty_n", 32'(EMPTY_N), 32'h0);
`ifdef FIFO_BANK_ERR_EN
      check("clr_err", 32'(ERR), 32'h0);
`endif

      // 6. Asynchronous reset between edges
      step(2'b11, 2'b00, 16'hC1D1, 1'b0);
      step(2'b10, 2'b00, 16'hC200, 1'b0);
      check("pre_rst_count1", 32'(cnt_of(1)), 32'd2);
      check("pre_rst_count0", 32'(cnt_of(0)), 32'd1);
      #1 RST = 1'b0;
      model_clear();
      #1;
      check("arst_empty_n", 32'(EMPTY_N), 32'h0);
      check("arst_count", 32'(COUNT), 32'h0);
      idle();
      RST = 1'b1;
      idle();

      // Random traffic, CLR rare, enqueue biased to reach full often
      for (int n = 0; n < 400; n++) begin
         logic [NCH-1:0] e, d;
         for (int i = 0; i < NCH; i++) begin
            e[i] = ($urandom_range(99) < 60);
            d[i] = ($urandom_range(99) < 45);
         end
         step(e, d, 16'($urandom), ($urandom_range(63) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fifo_bank.md
# fifo_bank

Parametrised bank of NCH independent synchronous FIFOs with configurable data width and depth. It replaces the fixed pair of 8-bit FIFO instances in the test wrapper with one generated block. Each channel has enqueue/dequeue handshakes, full/empty flags, an occupancy count, and first-word-fall-through output. It sits directly under the cocotb-facing wrapper and shares one clock, one reset and one synchronous clear across all channels.

## Interface
- WIDTH, 8: data bits per entry, at least 1.
- DEPTH, 4: entries per channel; a power of 2, at least 2.
- NCH, 2: number of channels, at least 1.
- CW, $clog2(DEPTH)+1: derived width of each count field; not for override.

Ports:
- CLK  in  1  rising-edge clock, the only clock.
- RST  in  1  one clock; reset is asynchronous and active-low.
- CLR  in  1  synchronous clear of all channels, active-high.
- ENQ  in  NCH  per-channel enqueue request; bit i belongs to channel i.
- DEQ  in  NCH  per-channel dequeue request.
- D_IN  in  NCH*WIDTH  channel i data in, at bits [i*WIDTH +: WIDTH].
- FULL_N  out  NCH  1 when channel i can accept an entry.
- EMPTY_N  out  NCH  1 when channel i holds at least one entry.
- D_OUT  out  NCH*WIDTH  head entry of channel i; 0 when the channel is empty.
- COUNT  out  NCH*CW  occupancy of channel i, from 0 to DEPTH.
- ERR  out  2*NCH  present only with FIFO_BANK_ERR_EN. Bit 2i is overflow and bit 2i+1 is underflow for channel i.

## Operation
- Each channel has a circular buffer, a write pointer, a read pointer and an occupancy counter. The pointers wrap modulo DEPTH with no gap.
- An enqueue is accepted when ENQ[i] is high and FULL_N[i] is high. It writes D_IN to the write pointer, advances the write pointer and adds 1 to the count.
- An enqueue is ignored when the channel is full, even if DEQ[i] is also high in the same cycle.
- A dequeue is accepted when DEQ[i] is high and EMPTY_N[i] is high. It advances the read pointer and subtracts 1 from the count.
- A dequeue is ignored when the channel is empty, even if ENQ[i] is also high. The enqueue still proceeds.
- Simultaneous accepted ENQ and DEQ on a non-empty, non-full channel: the count is unchanged and both pointers advance.
- Flags are derived from the count: FULL_N = (COUNT != DEPTH) and EMPTY_N = (COUNT != 0).
- D_OUT is first-word-fall-through. It shows the entry at the read pointer, masked to 0 while the channel is empty.
- CLR has priority over ENQ and DEQ in the same cycle. It zeroes all pointers and counts, so every channel becomes empty.
- CLR does not erase the storage array, but D_OUT still reads 0 because it is masked while empty.
- Channels are fully independent. Activity on one channel never changes another channel's state.
- Storage RAM is not reset.

## Timing
- Reset values while RST is low: FULL_N all 1s, EMPTY_N all 0s, D_OUT all 0s, COUNT all 0s, ERR all 0s. Pointers are 0.
- Asserting RST mid-operation empties all channels immediately, without waiting for a clock edge.
- All state changes happen on the CLK rising edge after RST deasserts.
- Enqueue to visibility latency is 1 cycle. After an enqueue at edge n into an empty channel, EMPTY_N, D_OUT and COUNT update right after edge n.
- Dequeue updates D_OUT to the next entry right after the same edge.
- All outputs are registered state or a combinational mask of registered state. There is no combinational path from any input to any output.

## Configuration
- Macro FIFO_BANK_ERR_EN compiles in the ERR port and its logic.
- Defined: ERR[2i] sets on an ignored ENQ[i] (channel full, CLR low). ERR[2i+1] sets on an ignored DEQ[i] (channel empty, CLR low).
- Both ERR bits are sticky. They clear only on RST low or CLR high; CLR wins over setting in the same cycle.
- Not defined: the ERR port and its logic are absent. Ignored requests are silently dropped and data-path behaviour is identical.

## Test plan
Run all scenarios with WIDTH=8, DEPTH=4, NCH=2.
1. Reset: hold RST=0 for 2 cycles -> FULL_N=2'b11, EMPTY_N=2'b00, D_OUT=0, COUNT=0.
2. Fill and drain channel 0: enqueue 0x11, 0x22, 0x33, 0x44, then one more enqueue of 0x55.
   - After the fourth enqueue -> FULL_N[0]=0 and COUNT0=4.
   - 0x55 is ignored; with FIFO_BANK_ERR_EN, ERR[0]=1.
   - Dequeue 4 times -> D_OUT0 shows 0x11, 0x22, 0x33, 0x44 in order, then EMPTY_N[0]=0 and D_OUT0=0.
3. Wrap-around: hold channel 0 at 2 entries while doing simultaneous ENQ and DEQ for 10 cycles with data 0xA0..0xA9 -> COUNT0 stays 2 and the output order is preserved across pointer wrap.
4. Full boundary: with channel 1 full, assert ENQ and DEQ together -> only the dequeue happens and COUNT1 goes 4 -> 3. With channel 1 empty, assert ENQ and DEQ with 0x7E -> COUNT1=1 and D_OUT1=0x7E.
5. CLR priority: with both channels holding 3 entries, assert CLR together with ENQ and DEQ -> next cycle COUNT=0, EMPTY_N=2'b00, and ERR is cleared.
6. Async reset mid-burst: drop RST between clock edges while channel 1 holds 2 entries -> EMPTY_N[1] falls immediately, without waiting for a clock edge, and channel 0 traffic is isolated throughout.
